// File: rtl/controle_decimacao_pkg.sv
// Shared types, codes and helpers for the block-average downscaler sequencer.
package decim_pkg;

    typedef enum logic [1:0] {
        SEL_F1       = 2'd0,
        SEL_F2       = 2'd1,
        SEL_F4       = 2'd2,
        SEL_INVALIDO = 2'd3
    } fator_sel_t;

    localparam logic [2:0] OCIOSO  = 3'd0;
    localparam logic [2:0] LE      = 3'd1;
    localparam logic [2:0] DRENA   = 3'd2;
    localparam logic [2:0] ESCREVE = 3'd3;
    localparam logic [2:0] FIM     = 3'd4;

    // Four guard bits let a 4x4 block of full-scale pixels accumulate without overflow.
    localparam int SOMA_GUARDA  = 4;
    localparam int DECIM_DATA_W = 8;
    localparam int SOMA_W       = DECIM_DATA_W + SOMA_GUARDA;

    function automatic logic [2:0] fator_de_sel(input logic [1:0] sel);
        case (sel)
            SEL_F1:  return 3'd1;
            SEL_F2:  return 3'd2;
            SEL_F4:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [2:0] shift_de_sel(input logic [1:0] sel);
        case (sel)
            SEL_F1:  return 3'd0;
            SEL_F2:  return 3'd2;
            SEL_F4:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/controle_decimacao_if.sv
// Command handshake plus input/output frame RAM ports of the decimation sequencer.
interface controle_decimacao_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 15
);
    logic              start;
    logic              abort;
    logic [1:0]        fator_sel;
    logic              busy;
    logic              done;
    logic              erro;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport slave (
        input  start, abort, fator_sel, rd_data,
        output busy, done, erro, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport master (
        output start, abort, fator_sel, rd_data,
        input  busy, done, erro, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/controle_decimacao_gerador_enderecos.sv
// Block anchor / in-block offset counters and the derived input and output RAM addresses.
module gerador_enderecos
    import decim_pkg::*;
#(
    parameter int LARGURA = 160,
    parameter int ALTURA  = 120,
    parameter int ADDR_W  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        fator_i,
    input  logic [1:0]        lg_fator_i,
    input  logic              step_i,
    input  logic              step_bloco_i,
    input  logic              clear_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              ultimo_pixel_o,
    output logic              ultimo_bloco_o
);
    logic [ADDR_W-1:0] linha_q, linha_d, coluna_q, coluna_d;
    logic [1:0]        di_q, di_d, dj_q, dj_d;
    logic [1:0]        fim_off_s;
    logic [ADDR_W-1:0] fator_s, ultima_linha_s, ultima_coluna_s;

    assign fim_off_s       = 2'(fator_i - 3'd1);
    assign fator_s         = ADDR_W'(fator_i);
    assign ultima_linha_s  = ADDR_W'(ALTURA) - fator_s;
    assign ultima_coluna_s = ADDR_W'(LARGURA) - fator_s;

    assign ultimo_pixel_o = (di_q == fim_off_s) && (dj_q == fim_off_s);
    assign ultimo_bloco_o = (linha_q == ultima_linha_s) && (coluna_q == ultima_coluna_s);

    // F is a power of two, so dividing the anchor by F is a shift by log2(F).
    assign rd_addr_o = ADDR_W'((int'(linha_q) + int'(di_q)) * LARGURA + int'(coluna_q) + int'(dj_q));
    assign wr_addr_o = ADDR_W'(int'(linha_q >> lg_fator_i) * (LARGURA >> lg_fator_i)
                               + int'(coluna_q >> lg_fator_i));

    // Next-state of offsets (dj fastest) and of the block anchor.
    always_comb begin
        linha_d  = linha_q;
        coluna_d = coluna_q;
        di_d     = di_q;
        dj_d     = dj_q;
        if (clear_i) begin
            linha_d  = {ADDR_W{1'b0}};
            coluna_d = {ADDR_W{1'b0}};
            di_d     = 2'd0;
            dj_d     = 2'd0;
        end else begin
            if (step_i) begin
                if (dj_q == fim_off_s) begin
                    dj_d = 2'd0;
                    di_d = (di_q == fim_off_s) ? 2'd0 : di_q + 2'd1;
                end else begin
                    dj_d = dj_q + 2'd1;
                end
            end else begin
                dj_d = dj_q;
            end
            if (step_bloco_i) begin
                if (coluna_q == ultima_coluna_s) begin
                    coluna_d = {ADDR_W{1'b0}};
                    linha_d  = (linha_q == ultima_linha_s) ? {ADDR_W{1'b0}} : linha_q + fator_s;
                end else begin
                    coluna_d = coluna_q + fator_s;
                end
            end else begin
                coluna_d = coluna_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            linha_q  <= {ADDR_W{1'b0}};
            coluna_q <= {ADDR_W{1'b0}};
            di_q     <= 2'd0;
            dj_q     <= 2'd0;
        end else begin
            linha_q  <= linha_d;
            coluna_q <= coluna_d;
            di_q     <= di_d;
            dj_q     <= dj_d;
        end
    end
endmodule

// File: rtl/controle_decimacao.sv
// Block-average downscaler sequencer: FSM and block accumulator.
// Build option DECIM_ARREDONDA_EN selects round-half-up averaging instead of truncation.
module controle_decimacao
    import decim_pkg::*;
#(
    parameter int LARGURA = 160,
    parameter int ALTURA  = 120,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 15
) (
    input logic                clk,
    input logic                rst,
    controle_decimacao_if.slave io
);
    localparam int SOMA_LW = DATA_W + SOMA_GUARDA;

    logic [2:0]         estado_q, estado_d;
    logic [2:0]         fator_q, fator_d, shift_q, shift_d;
    logic [1:0]         lg_q, lg_d;
    logic [SOMA_LW-1:0] soma_q, soma_d;
    logic [DATA_W-1:0]  wr_data_q;
    logic               rd_valid_q, rd_en_q, wr_en_q, busy_q, done_q, erro_q;
    logic               ocioso_s, aceita_s, invalido_s, cancela_s, clear_s;
    logic               ultimo_pixel_s, ultimo_bloco_s;

    function automatic logic [DATA_W-1:0] media(input logic [SOMA_LW-1:0] s, input logic [2:0] sh);
        logic [SOMA_LW-1:0] t;
`ifdef DECIM_ARREDONDA_EN
        t = s + ((SOMA_LW'(1'b1) << sh) >> 1);
`else
        t = s;
`endif
        return DATA_W'(t >> sh);
    endfunction

    assign ocioso_s   = (estado_q == OCIOSO);
    assign aceita_s   = ocioso_s && io.start && (io.fator_sel != SEL_INVALIDO);
    assign invalido_s = ocioso_s && io.start && (io.fator_sel == SEL_INVALIDO);
    assign cancela_s  = !ocioso_s && io.abort;
    assign clear_s    = aceita_s || cancela_s;

    gerador_enderecos #(
        .LARGURA (LARGURA),
        .ALTURA  (ALTURA),
        .ADDR_W  (ADDR_W)
    ) u_gerador (
        .clk            (clk),
        .rst            (rst),
        .fator_i        (fator_q),
        .lg_fator_i     (lg_q),
        .step_i         (estado_q == LE),
        .step_bloco_i   (estado_q == ESCREVE),
        .clear_i        (clear_s),
        .rd_addr_o      (io.rd_addr),
        .wr_addr_o      (io.wr_addr),
        .ultimo_pixel_o (ultimo_pixel_s),
        .ultimo_bloco_o (ultimo_bloco_s)
    );

    // Sequencer next state and factor latch.
    always_comb begin
        estado_d = estado_q;
        fator_d  = fator_q;
        shift_d  = shift_q;
        lg_d     = lg_q;
        case (estado_q)
            OCIOSO: begin
                if (aceita_s) begin
                    estado_d = LE;
                    fator_d  = fator_de_sel(io.fator_sel);
                    shift_d  = shift_de_sel(io.fator_sel);
                    lg_d     = 2'(shift_de_sel(io.fator_sel) >> 1);
                end else begin
                    estado_d = OCIOSO;
                end
            end
            LE:      estado_d = io.abort ? OCIOSO : (ultimo_pixel_s ? DRENA : LE);
            DRENA:   estado_d = io.abort ? OCIOSO : ESCREVE;
            ESCREVE: estado_d = io.abort ? OCIOSO : (ultimo_bloco_s ? FIM : LE);
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // Accumulator: a pixel returning one cycle after its read is always added.
    always_comb begin
        soma_d = soma_q;
        if (clear_s) begin
            soma_d = {SOMA_LW{1'b0}};
        end else if (estado_q == ESCREVE) begin
            soma_d = {SOMA_LW{1'b0}};
        end else if (rd_valid_q) begin
            soma_d = soma_q + SOMA_LW'(io.rd_data);
        end else begin
            soma_d = soma_q;
        end
    end

    // State, accumulator and registered outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            fator_q    <= 3'd1;
            shift_q    <= 3'd0;
            lg_q       <= 2'd0;
            soma_q     <= {SOMA_LW{1'b0}};
            rd_valid_q <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            erro_q     <= 1'b0;
            wr_data_q  <= {DATA_W{1'b0}};
        end else begin
            estado_q   <= estado_d;
            fator_q    <= fator_d;
            shift_q    <= shift_d;
            lg_q       <= lg_d;
            soma_q     <= soma_d;
            rd_valid_q <= rd_en_q;
            rd_en_q    <= (estado_d == LE);
            wr_en_q    <= (estado_d == ESCREVE);
            busy_q     <= (estado_d != OCIOSO);
            done_q     <= (estado_d == FIM);
            erro_q     <= invalido_s;
            // ESCREVE is only entered from DRENA, where soma_d already holds the whole block.
            if (estado_d == ESCREVE) begin
                wr_data_q <= media(soma_d, shift_q);
            end else begin
                wr_data_q <= wr_data_q;
            end
        end
    end

    assign io.busy    = busy_q;
    assign io.done    = done_q;
    assign io.erro    = erro_q;
    assign io.rd_en   = rd_en_q;
    assign io.wr_en   = wr_en_q;
    assign io.wr_data = wr_data_q;
endmodule

// File: tb/tb_controle_decimacao.sv
// Self-checking bench for controle_decimacao on a 4x4 frame (honours DECIM_ARREDONDA_EN).
module tb_controle_decimacao;
    localparam int L = 4;
    localparam int A = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    controle_decimacao_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    controle_decimacao #(.LARGURA(L), .ALTURA(A), .DATA_W(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int ram [16];
    int n_ok = 0;
    int n_tot = 0;

    // Input frame RAM: synchronous read, one cycle latency.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.rd_data <= 8'd0;
        else if (bus.rd_en) bus.rd_data <= 8'(ram[bus.rd_addr]);
    end

    // Monitor: sampled on the falling edge.
    logic clr_mon = 1'b0;
    int busy_cyc, done_cnt, erro_cnt, rd_cnt, wr_cnt, colisao;
    int wr_mem [16];
    int rd_log [64];
    logic rd_en_ant;
    always @(negedge clk) begin
        if (clr_mon) begin
            busy_cyc <= 0; done_cnt <= 0; erro_cnt <= 0; rd_cnt <= 0; wr_cnt <= 0;
            colisao <= 0; rd_en_ant <= 1'b0;
            for (int i = 0; i < 16; i++) wr_mem[i] <= -1;
        end else begin
            if (bus.busy) busy_cyc <= busy_cyc + 1;
            if (bus.done) done_cnt <= done_cnt + 1;
            if (bus.erro) erro_cnt <= erro_cnt + 1;
            if (bus.rd_en) begin
                if (rd_cnt < 64) rd_log[rd_cnt] <= int'(bus.rd_addr);
                rd_cnt <= rd_cnt + 1;
            end
            if (bus.wr_en) begin
                wr_cnt <= wr_cnt + 1;
                wr_mem[bus.wr_addr] <= int'(bus.wr_data);
                if (rd_en_ant) colisao <= colisao + 1;
            end
            rd_en_ant <= bus.rd_en;
        end
    end

    task automatic chk(input string nome, input int atual, input int esperado);
        n_tot++;
        if (atual == esperado) n_ok++;
        else $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic limpa_mon();
        clr_mon = 1'b1;
        @(negedge clk);
        tick();
        clr_mon = 1'b0;
    endtask

    // Issue a start, then optionally a second start or an abort in a given busy cycle.
    task automatic roda(input int sel, input int start_at, input int abort_at);
        int cyc;
        limpa_mon();
        bus.fator_sel = 2'(sel);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (bus.busy && cyc < 500) begin
            bus.abort = (cyc == abort_at);
            if (cyc == start_at) begin
                bus.start = 1'b1;
                bus.fator_sel = 2'd0;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("frame_terminates", int'(cyc < 500), 1);
        tick();
        tick();
    endtask

    task automatic confere(input string nome, input int eb, input int en, input int edone,
                           input logic [15:0][7:0] ed);
        chk({nome, "_busy"}, busy_cyc, eb);
        chk({nome, "_writes"}, wr_cnt, en);
        chk({nome, "_done"}, done_cnt, edone);
        chk({nome, "_erro"}, erro_cnt, 0);
        chk({nome, "_rdvalid_in_write"}, colisao, 0);
        for (int o = 0; o < en; o++) chk({nome, $sformatf("_wr%0d", o)}, wr_mem[o], int'(ed[o]));
    endtask

    // Reference: block averages straight from the frame contents.
    function automatic logic [15:0][7:0] modelo(input int f);
        logic [15:0][7:0] r;
        int nb, q, s;
        r = '0;
        nb = L / f;
        q = f * f;
        for (int o = 0; o < (L * A) / q; o++) begin
            s = 0;
            for (int y = 0; y < f; y++)
                for (int x = 0; x < f; x++)
                    s += ram[((o / nb) * f + y) * L + (o % nb) * f + x];
`ifdef DECIM_ARREDONDA_EN
            r[o] = 8'((s + q / 2) / q);
`else
            r[o] = 8'(s / q);
`endif
        end
        return r;
    endfunction

    typedef struct {
        int               sel;
        int               busy;
        int               nwr;
        logic [15:0][7:0] dados;
    } vetor_t;

    vetor_t tabela [3];

    initial begin
        int f;
        logic [15:0][7:0] esp;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.fator_sel = 2'd0;
        for (int i = 0; i < 16; i++) ram[i] = i + 1;

        tabela[0].sel = 1; tabela[0].busy = 25; tabela[0].nwr = 4; tabela[0].dados = '0;
        tabela[1].sel = 2; tabela[1].busy = 19; tabela[1].nwr = 1; tabela[1].dados = '0;
        tabela[2].sel = 0; tabela[2].busy = 49; tabela[2].nwr = 16; tabela[2].dados = '0;
`ifdef DECIM_ARREDONDA_EN
        tabela[0].dados[0] = 8'd4;  tabela[0].dados[1] = 8'd6;
        tabela[0].dados[2] = 8'd12; tabela[0].dados[3] = 8'd14;
        tabela[1].dados[0] = 8'd9;
`else
        tabela[0].dados[0] = 8'd3;  tabela[0].dados[1] = 8'd5;
        tabela[0].dados[2] = 8'd11; tabela[0].dados[3] = 8'd13;
        tabela[1].dados[0] = 8'd8;
`endif
        for (int i = 0; i < 16; i++) tabela[2].dados[i] = 8'(i + 1);

        // Reset state.
        repeat (3) tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_erro", int'(bus.erro), 0);
        chk("rst_rd_en", int'(bus.rd_en), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_rd_addr", int'(bus.rd_addr), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_data", int'(bus.wr_data), 0);
        rst = 1'b0;
        tick();

        // Table-driven frames on the ramp image.
        for (int t = 0; t < 3; t++) begin
            roda(tabela[t].sel, -1, -1);
            confere($sformatf("tab%0d", t), tabela[t].busy, tabela[t].nwr, 1, tabela[t].dados);
        end
        for (int i = 0; i < 16; i++) chk($sformatf("f1_rd_order%0d", i), rd_log[i], i);

        // Invalid factor: error pulse only.
        roda(3, -1, -1);
        chk("inv_erro_pulse", erro_cnt, 1);
        chk("inv_busy", busy_cyc, 0);
        chk("inv_rd", rd_cnt, 0);
        chk("inv_wr", wr_cnt, 0);

        // Second start (with a different factor) mid-frame is ignored.
        roda(1, 5, -1);
        confere("restart_ignored", 25, 4, 1, tabela[0].dados);

        // Abort in the 8th busy cycle: one write, no done; then a full frame.
        roda(1, -1, 8);
        esp = '0;
        esp[0] = tabela[0].dados[0];
        confere("abort", 8, 1, 0, esp);
        roda(1, -1, -1);
        confere("after_abort", 25, 4, 1, tabela[0].dados);

        // Reset while reading.
        limpa_mon();
        bus.fator_sel = 2'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_rd_en", int'(bus.rd_en), 0);
        chk("midrst_rd_addr", int'(bus.rd_addr), 0);
        chk("midrst_wr_data", int'(bus.wr_data), 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("midrst_no_write", wr_cnt, 0);
        roda(1, -1, -1);
        confere("after_rst", 25, 4, 1, tabela[0].dados);

        // Random frames against the reference model; last one is full-scale.
        for (int it = 0; it < 9; it++) begin
            int sel;
            sel = (it == 8) ? 2 : int'($urandom_range(0, 2));
            for (int i = 0; i < 16; i++) ram[i] = (it == 8) ? 255 : int'($urandom_range(0, 255));
            f = 1 << sel;
            roda(sel, -1, -1);
            confere($sformatf("rnd%0d_f%0d", it, f), (16 / (f * f)) * (f * f + 2) + 1,
                    16 / (f * f), 1, modelo(f));
        end

        $display("%0d/%0d checks passed", n_ok, n_tot);
        $finish;
    end
endmodule
